// File: rtl/d_branch_resolver_if.sv
// rtl/d_branch_resolver_if.sv - D-stage branch resolver signal bundle
// Purpose: groups the D-stage operand/control inputs and the resolution and
//          statistics outputs of d_branch_resolver into one interface.
// Ports (signals):
//   valid_d, stall, br_op, a_d, b_d, pc_d          : driven by the D stage (master)
//   taken, pred_taken, mispredict, mispredict_q,
//   branch_cnt, mispred_cnt                       : driven by the resolver (slave)
interface d_branch_resolver_if #(
   parameter int WIDTH = 32,
   parameter int PC_W  = 32,
   parameter int CNT_W = 32
);
   logic             valid_d;
   logic             stall;
   logic [2:0]       br_op;
   logic [WIDTH-1:0] a_d;
   logic [WIDTH-1:0] b_d;
   logic [PC_W-1:0]  pc_d;
   logic             taken;
   logic             pred_taken;
   logic             mispredict;
   logic             mispredict_q;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] mispred_cnt;

   modport master (
      output valid_d, stall, br_op, a_d, b_d, pc_d,
      input  taken, pred_taken, mispredict, mispredict_q, branch_cnt, mispred_cnt
   );

   modport slave (
      input  valid_d, stall, br_op, a_d, b_d, pc_d,
      output taken, pred_taken, mispredict, mispredict_q, branch_cnt, mispred_cnt
   );
endinterface

// File: rtl/d_branch_resolver.sv
// rtl/d_branch_resolver.sv - D-stage branch resolution with 2-bit predictor table
// Purpose: evaluates beq/bne/blez/bgtz/bltz/bgez on forwarded D-stage operands,
//          looks up a PC-indexed table of 2-bit saturating predictors, flags
//          mispredictions and keeps retired-branch / mispredict counters.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous reset, active-low
//   bus    : d_branch_resolver_if slave modport
//            in  valid_d, stall, br_op[2:0], a_d, b_d, pc_d
//            out taken, pred_taken, mispredict (combinational)
//            out mispredict_q, branch_cnt, mispred_cnt (registered)
module d_branch_resolver #(
   parameter int WIDTH = 32,
   parameter int PC_W  = 32,
   parameter int IDX_W = 4,
   parameter int CNT_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   d_branch_resolver_if.slave    bus
);
   localparam int DEPTH = 2 ** IDX_W;

   localparam logic [2:0] OP_BEQ  = 3'd1;
   localparam logic [2:0] OP_BNE  = 3'd2;
   localparam logic [2:0] OP_BLEZ = 3'd3;
   localparam logic [2:0] OP_BGTZ = 3'd4;
   localparam logic [2:0] OP_BLTZ = 3'd5;
   localparam logic [2:0] OP_BGEZ = 3'd6;

   logic [1:0]       pred_table [DEPTH];
   logic             mispredict_r;
   logic [CNT_W-1:0] branch_cnt_r;
   logic [CNT_W-1:0] mispred_cnt_r;

   logic             live;
   logic             retire;
   logic             cond;
   logic             a_neg;
   logic             a_zero;
   logic [IDX_W-1:0] index;
   logic [1:0]       ctr;
   logic             taken_c;
   logic             pred_c;
   logic             mispredict_c;

   // Ops 0 and 7 are not branches.
   assign live   = bus.valid_d && (bus.br_op != 3'd0) && (bus.br_op != 3'd7);
   assign retire = live && !bus.stall;

   assign a_neg  = bus.a_d[WIDTH-1];
   assign a_zero = (bus.a_d == '0);

   always_comb begin
      cond = 1'b0;
      case (bus.br_op)
         OP_BEQ:  cond = (bus.a_d == bus.b_d);
         OP_BNE:  cond = (bus.a_d != bus.b_d);
         OP_BLEZ: cond = a_neg || a_zero;
         OP_BGTZ: cond = !a_neg && !a_zero;
         OP_BLTZ: cond = a_neg;
         OP_BGEZ: cond = !a_neg;
         default: cond = 1'b0;
      endcase
   end

   // Word-aligned PC: the two LSBs carry no information.
   assign index        = bus.pc_d[IDX_W+1:2];
   assign ctr          = pred_table[index];
   assign taken_c      = live && cond;
   assign pred_c       = live && ctr[1];
   assign mispredict_c = live && (pred_c != taken_c);

   // Table update; the comb read above sees the pre-edge value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pred_table[i] <= 2'b01;
         end
      end else if (retire) begin
         if (taken_c) begin
            if (ctr != 2'b11) pred_table[index] <= ctr + 2'b01;
         end else begin
            if (ctr != 2'b00) pred_table[index] <= ctr - 2'b01;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mispredict_r  <= 1'b0;
         branch_cnt_r  <= '0;
         mispred_cnt_r <= '0;
      end else begin
         mispredict_r <= retire && mispredict_c;
         if (retire) begin
            branch_cnt_r <= branch_cnt_r + 1'b1;
            if (mispredict_c) mispred_cnt_r <= mispred_cnt_r + 1'b1;
         end
      end
   end

   assign bus.taken        = taken_c;
   assign bus.pred_taken   = pred_c;
   assign bus.mispredict   = mispredict_c;
   assign bus.mispredict_q = mispredict_r;
   assign bus.branch_cnt   = branch_cnt_r;
   assign bus.mispred_cnt  = mispred_cnt_r;
endmodule
